ctrl_pipe: RTL

Parametrised main control unit for the pipelined RV32I core. It decodes the 7-bit opcode in the Decode stage into the datapath control word, then carries that word through the ID/EX, EX/MEM and MEM/WB control registers, with stall and flush support for the hazard unit. It adds optional LUI/AUIPC/JALR decoding, deterministic (non-X) outputs for unknown opcodes, and a saturating counter of illegal instructions that retire.

---
 rtl/ctrl_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// Main control decoder for the RV32I pipeline: decodes the opcode in D and carries
// the control word through ID/EX, EX/MEM and MEM/WB, counting retired illegal opcodes.
module ctrl_pipe #(
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic [2:0]       ImmSrcD,
  output logic             IllegalD,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             JalrE,
  output logic             ALUSrcE,
  output logic             ALUSrcAE,
  output logic [1:0]       ResultSrcE,
  output logic [1:0]       ALUOpE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src_a;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jalr;
  } dec_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src_a;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jalr;
    logic       illegal;
  } e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       illegal;
  } m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal;
  } w_t;

  localparam bit EXT = (EXT_OPS != 0);

  dec_t w_dec;
  logic w_ill;
  e_t   w_e_next;
  e_t   r_e;
  m_t   r_m;
  w_t   r_w;
  logic [CNT_W-1:0] r_cnt;

  // Field order: reg_write, imm_src, alu_src_a, alu_src, mem_write, result_src, branch, alu_op, jump, jalr
  always_comb begin
    w_dec = '0;
    w_ill = 1'b0;
    case (op)
      7'b0000011: w_dec = 14'b1_000_0_1_0_01_0_00_0_0;
      7'b0100011: w_dec = 14'b0_001_0_1_1_00_0_00_0_0;
      7'b0110011: w_dec = 14'b1_000_0_0_0_00_0_10_0_0;
      7'b1100011: w_dec = 14'b0_010_0_0_0_00_1_01_0_0;
      7'b0010011: w_dec = 14'b1_000_0_1_0_00_0_10_0_0;
      7'b1101111: w_dec = 14'b1_011_0_0_0_10_0_00_1_0;
      7'b1100111: if (EXT) w_dec = 14'b1_000_0_1_0_10_0_00_1_1; else w_ill = 1'b1;
      7'b0110111: if (EXT) w_dec = 14'b1_100_0_1_0_11_0_00_0_0; else w_ill = 1'b1;
      7'b0010111: if (EXT) w_dec = 14'b1_100_1_1_0_00_0_00_0_0; else w_ill = 1'b1;
      default:    w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_e_next            = '0;
    w_e_next.reg_write  = w_dec.reg_write;
    w_e_next.alu_src_a  = w_dec.alu_src_a;
    w_e_next.alu_src    = w_dec.alu_src;
    w_e_next.mem_write  = w_dec.mem_write;
    w_e_next.result_src = w_dec.result_src;
    w_e_next.branch     = w_dec.branch;
    w_e_next.alu_op     = w_dec.alu_op;
    w_e_next.jump       = w_dec.jump;
    w_e_next.jalr       = w_dec.jalr;
    w_e_next.illegal    = w_ill;
  end

  // A stall always bubbles EX/MEM, so flush+stall leaves both E and M empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e   <= '0;
      r_m   <= '0;
      r_w   <= '0;
      r_cnt <= '0;
    end else begin
      if (flush_e)      r_e <= '0;
      else if (!stall_e) r_e <= w_e_next;

      if (stall_e) r_m <= '0;
      else         r_m <= '{r_e.reg_write, r_e.mem_write, r_e.result_src, r_e.illegal};

      r_w <= '{r_m.reg_write, r_m.result_src, r_m.illegal};

      if (r_w.illegal && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ImmSrcD     = w_dec.imm_src;
  assign IllegalD    = w_ill;
  assign RegWriteE   = r_e.reg_write;
  assign MemWriteE   = r_e.mem_write;
  assign BranchE     = r_e.branch;
  assign JumpE       = r_e.jump;
  assign JalrE       = r_e.jalr;
  assign ALUSrcE     = r_e.alu_src;
  assign ALUSrcAE    = r_e.alu_src_a;
  assign ResultSrcE  = r_e.result_src;
  assign ALUOpE      = r_e.alu_op;
  assign RegWriteM   = r_m.reg_write;
  assign MemWriteM   = r_m.mem_write;
  assign ResultSrcM  = r_m.result_src;
  assign RegWriteW   = r_w.reg_write;
  assign ResultSrcW  = r_w.result_src;
  assign illegal_cnt = r_cnt;

endmodule
